nv_nvdla_sdp_param_cq: RTL
==========================

NV_NVDLA_SDP_PARAM_CQ -- requirements
Module: NV_NVDLA_SDP_param_cq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, payload bit width (1..512).
REQ-002 SHALL have parameter DEPTH, default 80, entry count (2..1024, any integer, not only powers of 2).
REQ-003 SHALL have parameter AFULL_GAP, default 4, almost-full asserted when free entries <= AFULL_GAP.
REQ-004 SHALL derive localparam AW = clog2(DEPTH+1) for count width and clog2(DEPTH) for address width.
REQ-005 SHALL have port nvdla_core_clk  input  1  sole clock.
REQ-006 SHALL have port nvdla_core_rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port ig2cq_pvld  input  1  write request.
REQ-008 SHALL have port ig2cq_prdy  output  1  write ready.
REQ-009 SHALL have port ig2cq_pd  input  WIDTH  write payload.
REQ-010 SHALL have port cq2eg_pvld  output  1  read data valid.
REQ-011 SHALL have port cq2eg_prdy  input  1  read ready.
REQ-012 SHALL have port cq2eg_pd  output  WIDTH  read payload.
REQ-013 SHALL have port cq_wr_limit  input  AW  runtime occupancy cap; 0 or >DEPTH means DEPTH.
REQ-014 SHALL have port cq_flush  input  1  synchronous discard of all contents.
REQ-015 SHALL have port cq_count  output  AW  write-side occupancy.
REQ-016 SHALL have port cq_afull  output  1  almost-full status.
REQ-017 SHALL have port cq_idle  output  1  no entries held and no read data pending.
REQ-018 SHALL have port pwrbus_ram_pd  input  32  RAM power control, passed to storage.

Function
REQ-019 Accept = ig2cq_pvld && ig2cq_prdy; pop = cq2eg_pvld && cq2eg_prdy; payload written in the accept cycle.
REQ-020 ig2cq_prdy SHALL be a registered signal: next value = !(count_next >= eff_limit), eff_limit per REQ-013.
REQ-021 cq_count SHALL increment on accept and decrement one cycle after pop (credit return delay 1); simultaneous accept and returned credit leave it unchanged.
REQ-022 First-word latency SHALL be 2 cycles: accept in cycle N into empty queue gives cq2eg_pvld=1 in cycle N+2.
REQ-023 Sustained throughput SHALL be one accept and one pop per cycle with cq_count held constant.
REQ-024 cq2eg_pvld/cq2eg_pd SHALL hold stable while cq2eg_prdy=0 (no drop, no change).
REQ-025 Data SHALL emerge in strict FIFO order; read and write pointers wrap from DEPTH-1 to 0.
REQ-026 Same-address write and read in one cycle SHALL never return the partially written word; the read side uses only entries whose write completed at least 1 cycle earlier.
REQ-027 Lowering cq_wr_limit below cq_count SHALL deassert ig2cq_prdy next cycle without loss of stored data.
REQ-028 cq_afull SHALL be registered, = (eff_limit - count_next) <= AFULL_GAP.
REQ-029 cq_flush=1 in cycle N SHALL, from cycle N+1, zero all pointers, counts and pending returns, and deassert cq2eg_pvld; an accept in cycle N SHALL be discarded; ig2cq_prdy SHALL be 0 in N+1 and 1 in N+2.
REQ-030 Count arithmetic SHALL never wrap: no increment at eff_limit and no decrement at 0 (assertions in simulation).
REQ-031 Clock gating SHALL enable the internal clock only on accept, pop, credit return, flush or ready change.

Reset
REQ-032 On nvdla_core_rstn low: ig2cq_prdy=0, cq2eg_pvld=0, cq_count=0, cq_afull=0, cq_idle=1, pointers=0; cq2eg_pd undefined.
REQ-033 ig2cq_prdy SHALL rise 1 cycle after reset release.
REQ-034 Reset mid-operation SHALL discard all contents immediately (asynchronous) with no residual valid after release.

Verification
REQ-035 Single write 0xA5A5 into empty queue -> cq2eg_pvld=1, cq2eg_pd=0xA5A5 exactly 2 cycles later; cq_count 1 then 0 one cycle after pop.
REQ-036 80 writes, cq2eg_prdy=0 -> ig2cq_prdy=0 after 80th, cq_afull=1 from count 76; drain returns values 0..79 in order.
REQ-037 cq_wr_limit=10, continuous writes -> exactly 10 accepted, prdy low; limit raised to 0 -> prdy high next cycle.
REQ-038 Full-rate streaming, 500 words, prdy/vld both 1 -> zero bubbles after fill, pointer wrap at 79 correct.
REQ-039 cq_flush with 37 entries and a simultaneous write -> cq_count=0, cq2eg_pvld=0 next cycle, next written word is first read.
REQ-040 Random backpressure with WIDTH=64, DEPTH=5 -> scoreboard match, stable pd under stall.

Source files
------------

// File: rtl/nv_nvdla_sdp_param_cq.sv
// Credit-managed parameter queue between SDP ingress and egress.
// The write side counts an entry until one cycle after its pop; the read side sees it two cycles after the write.
module nv_nvdla_sdp_param_cq #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 80,
  parameter int AFULL_GAP = 4,
  localparam int AW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             ig2cq_pvld,
  output logic             ig2cq_prdy,
  input  logic [WIDTH-1:0] ig2cq_pd,
  output logic             cq2eg_pvld,
  input  logic             cq2eg_prdy,
  output logic [WIDTH-1:0] cq2eg_pd,
  input  logic [AW-1:0]    cq_wr_limit,
  input  logic             cq_flush,
  output logic [AW-1:0]    cq_count,
  output logic             cq_afull,
  output logic             cq_idle,
  input  logic [31:0]      pwrbus_ram_pd
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] count;
  logic [AW-1:0] count_next;
  logic [AW-1:0] rd_avail;
  logic [AW-1:0] rd_avail_next;
  logic [AW-1:0] eff_limit;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic          prdy;
  logic          prdy_next;
  logic          afull;
  logic          afull_next;
  logic          credit_ret;
  logic          wr_pushed;
  logic          accept;
  logic          pop;
  logic          clk_en;
  logic          unused_pwrbus;

  // Power control has no effect on the flop-based storage model.
  assign unused_pwrbus = ^pwrbus_ram_pd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign eff_limit = ((cq_wr_limit == '0) || (cq_wr_limit > AW'(DEPTH))) ? AW'(DEPTH) : cq_wr_limit;

  assign accept     = ig2cq_pvld && prdy;
  assign cq2eg_pvld = (rd_avail != '0);
  assign pop        = cq2eg_pvld && cq2eg_prdy;

  always_comb begin
    count_next    = count;
    rd_avail_next = rd_avail;
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    if (cq_flush) begin
      count_next    = '0;
      rd_avail_next = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
    end else begin
      case ({accept, credit_ret})
        2'b10:   count_next = count + AW'(1);
        2'b01:   count_next = count - AW'(1);
        default: count_next = count;
      endcase
      rd_avail_next = rd_avail + AW'(wr_pushed) - AW'(pop);
      if (accept) wr_ptr_next = bump(wr_ptr);
      if (pop)    rd_ptr_next = bump(rd_ptr);
    end
  end

  // A lowered limit can leave count above eff_limit; the signed difference keeps afull high then.
  always_comb begin
    prdy_next  = !cq_flush && !(count_next >= eff_limit);
    afull_next = (int'(eff_limit) - int'(count_next)) <= AFULL_GAP;
  end

  // State only advances when something observable can change.
  assign clk_en = accept || pop || credit_ret || wr_pushed || cq_flush ||
                  (prdy_next != prdy) || (afull_next != afull);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      count      <= '0;
      rd_avail   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      prdy       <= 1'b0;
      afull      <= 1'b0;
      credit_ret <= 1'b0;
      wr_pushed  <= 1'b0;
    end else if (clk_en) begin
      count      <= count_next;
      rd_avail   <= rd_avail_next;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      prdy       <= prdy_next;
      afull      <= afull_next;
      credit_ret <= pop && !cq_flush;
      wr_pushed  <= accept && !cq_flush;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (accept && !cq_flush) mem[wr_ptr] <= ig2cq_pd;
  end

  assign cq2eg_pd   = mem[rd_ptr];
  assign ig2cq_prdy = prdy;
  assign cq_count   = count;
  assign cq_afull   = afull;
  assign cq_idle    = (count == '0) && (rd_avail == '0);

  a_no_underflow: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !(credit_ret && count == '0));
  a_no_overflow: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !(accept && !credit_ret && count == AW'(DEPTH)));

endmodule
